cmsdk_ahb_mem_arbiter: RTL and testbench
========================================

# cmsdk_ahb_mem_arbiter

Shares one single-ported, 16-bank external memory between the AHB slave path and a secondary word-access requester such as a loader or DMA engine. Sequences every memory command: at most one read or write per cycle, with a one-hot bank chip select and byte enables. Inserts AHB wait states when the port is unavailable or read data is pending. A starvation counter bounds how long the secondary requester can wait.

## Interface
- STARVE_LIMIT, 4: consecutive cycles the secondary may wait before it takes priority; legal range 1..15.
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL, HREADY, HWRITE  in  1 each  AHB select, bus ready, write
- HTRANS  in  2  AHB transfer type; only NONSEQ/SEQ (bit 1 set) are accepted
- HSIZE  in  3  byte/half/word
- HADDR  in  32  [27:24] bank, [23:2] word, [1:0] byte lane
- HWDATA  in  32  write data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  tied 0 (OKAY)
- HRDATA  out  32  equals mem_rdata
- sec_req, sec_write  in  1 each  secondary request, write
- sec_addr  in  26  [25:22] bank, [21:0] word
- sec_wdata  in  32  write data
- sec_gnt  out  1  request issued this cycle
- sec_rvalid  out  1  read data valid on sec_rdata
- sec_rdata  out  32  equals mem_rdata
- mem_addr  out  22  word address
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables
- mem_w_en, mem_r_en  out  1 each  command; never both high
- mem_cs  out  16  one-hot bank select; zero when no command
- mem_rdata  in  32  read data, valid the cycle after mem_r_en

## Operation
- AHB transfer is accepted when HSEL & HREADY & HTRANS[1]. On acceptance, register the write flag, HADDR[27:0] and HSIZE.
- Data-phase FSM:
  - IDLE -> WR when the accepted transfer is a write.
  - IDLE -> RD_ISSUE when the accepted transfer is a read.
  - WR: requests the port. When granted, it writes HWDATA and HREADYOUT=1. When not granted, it stays in WR with HREADYOUT=0.
  - RD_ISSUE: HREADYOUT=0. When granted, it issues the read and moves to RD_DATA.
  - RD_DATA: HREADYOUT=1 and HRDATA = mem_rdata. The port is free for the secondary.
  - On the cycle a data phase completes, a newly accepted transfer goes directly to WR or RD_ISSUE; otherwise the FSM returns to IDLE.
- Port grant, each cycle:
  - AHB (WR or RD_ISSUE) has priority.
  - Exception: when wait_cnt >= STARVE_LIMIT and sec_req=1, the secondary is granted instead and AHB stalls one cycle.
  - The secondary is otherwise granted whenever the AHB is not using the port.
- wait_cnt (4 bits):
  - +1 each cycle sec_req & !sec_gnt, saturating at 15.
  - Cleared on sec_gnt or when sec_req=0.
- sec_gnt is combinational in the issue cycle. The requester may change its request on the next cycle. sec_rvalid is registered high one cycle after a granted read.
- mem_be:
  - Secondary: always 4'hF.
  - AHB word: 4'hF.
  - AHB half: 4'b0011 << (2·addr[1]).
  - AHB byte: 4'b0001 << addr[1:0].
  - Reads use the same mem_be.
- mem_cs = 1 << bank when mem_w_en | mem_r_en, else 16'h0.
- IDLE/BUSY transfers and unselected cycles: no command, no state change.

## Timing
- Reset values:
  - HREADYOUT=1, HRESP=0, sec_gnt=0, sec_rvalid=0.
  - mem_w_en=0, mem_r_en=0, mem_cs=0.
  - FSM=IDLE, wait_cnt=0.
- AHB write: 0 wait states when granted. The memory write occurs in the data-phase cycle.
- AHB read: 1 wait state minimum (RD_ISSUE, then RD_DATA).
- Each starvation override adds exactly one wait state.
- Secondary read: data arrives 1 cycle after sec_gnt.
- Simultaneous starvation and an AHB read in RD_ISSUE: the secondary wins. The AHB read issues the next cycle, and wait_cnt is 0 at that point.
- Reset mid-transfer: the in-flight write is lost, and a pending sec_rvalid is dropped.

## Structure
- Package cmsdk_ahb_mem_pkg contains:
  - FSM state enum: IDLE, WR, RD_ISSUE, RD_DATA.
  - HTRANS codes.
  - BANK_W=4 and WORD_W=22.
  - HSIZE encodings.
- Sub-module cmsdk_ahb_mem_bank_dec: bank -> one-hot cs, and size/addr -> mem_be. Purely combinational.

## Test plan
- AHB word write 0x1200_0010 = 0xDEADBEEF, no secondary activity:
  - mem_w_en=1 in the data phase, mem_addr=0x000004, mem_cs=16'h0004, mem_be=4'hF.
  - HREADYOUT stays 1.
- AHB byte read at 0x0F00_0003:
  - RD_ISSUE cycle: HREADYOUT=0, mem_r_en=1, mem_be=4'b1000, mem_cs=16'h8000.
  - Next cycle: HREADYOUT=1, HRDATA = mem_rdata.
- Back-to-back AHB write then read:
  - Write completes with no wait.
  - Read takes exactly one wait state.
  - mem_w_en and mem_r_en are never high together.
- sec_req held high during continuous AHB writes, STARVE_LIMIT=4:
  - sec_gnt is first asserted in the 5th cycle, with HREADYOUT=0 that cycle.
  - wait_cnt returns to 0 afterwards.
- Secondary read of bank 3, word 0x2A while AHB is idle:
  - Same cycle: sec_gnt=1, mem_r_en=1, mem_cs=16'h0008.
  - Next cycle: sec_rvalid=1.
- HRESETn asserted during RD_ISSUE:
  - Outputs return to their reset values immediately (asynchronous).
  - After release, the FSM is in IDLE and HREADYOUT=1.

Source files
------------

// File: rtl/cmsdk_ahb_mem_pkg.sv
// Shared types and constants for the AHB / secondary memory arbiter.
// Holds the FSM state enum, the HTRANS and HSIZE codes, and the address field widths.
package cmsdk_ahb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_DATA
    } state_t;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam int unsigned BANK_W = 4;
    localparam int unsigned WORD_W = 22;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/cmsdk_ahb_mem_bank_dec.sv
// Combinational decode of bank number into a one-hot chip select, and of transfer
// size and byte lane into byte enables.
module cmsdk_ahb_mem_bank_dec
    import cmsdk_ahb_mem_pkg::*;
(
    input  logic                      en,
    input  logic [BANK_W-1:0]         bank,
    input  logic                      full_word,
    input  logic [2:0]                size,
    input  logic [1:0]                lane,
    output logic [(1 << BANK_W)-1:0]  cs,
    output logic [3:0]                be
);

    always_comb begin
        cs = '0;
        if (en) begin
            cs[bank] = 1'b1;
        end
        be = '1;
        // Secondary accesses are always full words, whatever HSIZE/lane happen to hold.
        if (!full_word) begin
            case (size)
                HSIZE_BYTE: be = 4'b0001 << lane;
                HSIZE_HALF: be = 4'b0011 << {lane[1], 1'b0};
                default:    be = '1;
            endcase
        end
    end

endmodule

// File: rtl/cmsdk_ahb_mem_arbiter.sv
// Arbitrates one single-ported 16-bank memory between the AHB slave data phase and a
// secondary word requester, with a starvation bound on the secondary's wait.
module cmsdk_ahb_mem_arbiter
    import cmsdk_ahb_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic                      HREADY,
    input  logic                      HWRITE,
    input  logic [1:0]                HTRANS,
    input  logic [2:0]                HSIZE,
    input  logic [31:0]               HADDR,
    input  logic [31:0]               HWDATA,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic [31:0]               HRDATA,
    input  logic                      sec_req,
    input  logic                      sec_write,
    input  logic [BANK_W+WORD_W-1:0]  sec_addr,
    input  logic [31:0]               sec_wdata,
    output logic                      sec_gnt,
    output logic                      sec_rvalid,
    output logic [31:0]               sec_rdata,
    output logic [WORD_W-1:0]         mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_be,
    output logic                      mem_w_en,
    output logic                      mem_r_en,
    output logic [(1 << BANK_W)-1:0]  mem_cs,
    input  logic [31:0]               mem_rdata
);

    state_t      state;
    logic [27:0] a_addr;
    logic [2:0]  a_size;
    logic [3:0]  wait_cnt;

    logic accept, ahb_req, starve, ahb_gnt, phase_done;
    logic [BANK_W-1:0] bank;
    logic [3:0] unused_haddr;

    assign unused_haddr = HADDR[31:28];

    assign accept     = HSEL && HREADY &&
                        (htrans_t'(HTRANS) == HTRANS_NONSEQ || htrans_t'(HTRANS) == HTRANS_SEQ);
    assign ahb_req    = (state == WR) || (state == RD_ISSUE);
    assign starve     = sec_req && (wait_cnt >= 4'(STARVE_LIMIT));
    assign ahb_gnt    = ahb_req && !starve;
    assign sec_gnt    = sec_req && (!ahb_req || starve);
    assign phase_done = (state == IDLE) || (state == RD_DATA) || (state == WR && ahb_gnt);

    assign mem_w_en  = (ahb_gnt && state == WR) || (sec_gnt && sec_write);
    assign mem_r_en  = (ahb_gnt && state == RD_ISSUE) || (sec_gnt && !sec_write);
    assign mem_addr  = ahb_gnt ? a_addr[23:2] : sec_addr[WORD_W-1:0];
    assign mem_wdata = ahb_gnt ? HWDATA : sec_wdata;
    assign bank      = ahb_gnt ? a_addr[27:24] : sec_addr[BANK_W+WORD_W-1:WORD_W];

    assign HREADYOUT = (state == IDLE) || (state == RD_DATA) || (state == WR && ahb_gnt);
    assign HRESP     = 1'b0;
    assign HRDATA    = mem_rdata;
    assign sec_rdata = mem_rdata;

    cmsdk_ahb_mem_bank_dec u_bank_dec (
        .en        (mem_w_en || mem_r_en),
        .bank      (bank),
        .full_word (!ahb_gnt),
        .size      (a_size),
        .lane      (a_addr[1:0]),
        .cs        (mem_cs),
        .be        (mem_be)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            a_addr     <= '0;
            a_size     <= '0;
            wait_cnt   <= '0;
            sec_rvalid <= 1'b0;
        end else begin
            // A read that wins the port moves on; any finished data phase may take the next transfer.
            if (state == RD_ISSUE && ahb_gnt) begin
                state <= RD_DATA;
            end else if (phase_done) begin
                if (accept) begin
                    state  <= HWRITE ? WR : RD_ISSUE;
                    a_addr <= HADDR[27:0];
                    a_size <= HSIZE;
                end else begin
                    state <= IDLE;
                end
            end

            if (!sec_req || sec_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != 4'hF) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            sec_rvalid <= sec_gnt && !sec_write;
        end
    end

endmodule

// File: tb/tb_cmsdk_ahb_mem_arbiter.sv
// Directed and randomized checks of the memory arbiter against a transaction-level
// model of the AHB data phase, the secondary wait count and the memory command.
module tb_cmsdk_ahb_mem_arbiter;

    localparam int LIM = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL, HREADY, HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR, HWDATA;
    logic        HREADYOUT, HRESP;
    logic [31:0] HRDATA;
    logic        sec_req, sec_write;
    logic [25:0] sec_addr;
    logic [31:0] sec_wdata;
    logic        sec_gnt, sec_rvalid;
    logic [31:0] sec_rdata;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_w_en, mem_r_en;
    logic [15:0] mem_cs;
    logic [31:0] mem_rdata;

    always #5 HCLK = ~HCLK;

    cmsdk_ahb_mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .sec_req(sec_req), .sec_write(sec_write), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
        .sec_gnt(sec_gnt), .sec_rvalid(sec_rvalid), .sec_rdata(sec_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_cs(mem_cs), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    // Model: pending AHB operation (0 none, 1 write, 2 read), read-return flag,
    // secondary wait count, secondary read-valid pending, latched address/size.
    int          m_op;
    bit          m_rret;
    int          m_wait;
    bit          m_srv;
    logic [27:0] m_addr;
    logic [2:0]  m_size;
    bit          e_sg, e_ag, e_w, e_r, e_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ahb_be(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            3'd0:    return 4'(1 << lane);
            3'd1:    return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'hF;
        endcase
    endfunction

    task automatic model_reset();
        m_op = 0; m_rret = 0; m_wait = 0; m_srv = 0; m_addr = '0; m_size = '0;
    endtask

    // Called at posedge+1 with inputs already set; checks at posedge+4.
    task automatic eval();
        bit need, starve;
        logic [3:0]  bnk;
        logic [21:0] wrd;
        logic [3:0]  be;
        logic [31:0] wd;
        need   = (m_op != 0);
        starve = sec_req && (m_wait >= LIM);
        e_sg   = sec_req && (!need || starve);
        e_ag   = need && !starve;
        e_w    = (e_ag && m_op == 1) || (e_sg && sec_write);
        e_r    = (e_ag && m_op == 2) || (e_sg && !sec_write);
        e_ready = !need || (m_op == 1 && e_ag);
        HREADY = e_ready;
        #3;
        chk("hreadyout", 32'(HREADYOUT), 32'(e_ready));
        chk("hresp", 32'(HRESP), 32'd0);
        chk("sec_gnt", 32'(sec_gnt), 32'(e_sg));
        chk("mem_w_en", 32'(mem_w_en), 32'(e_w));
        chk("mem_r_en", 32'(mem_r_en), 32'(e_r));
        chk("sec_rvalid", 32'(sec_rvalid), 32'(m_srv));
        chk("wait_cnt", 32'(dut.wait_cnt), 32'(m_wait));
        if (e_ag) begin
            bnk = m_addr[27:24]; wrd = m_addr[23:2]; be = ahb_be(m_size, m_addr[1:0]); wd = HWDATA;
        end else begin
            bnk = sec_addr[25:22]; wrd = sec_addr[21:0]; be = 4'hF; wd = sec_wdata;
        end
        chk("mem_cs", 32'(mem_cs), (e_w || e_r) ? (32'd1 << bnk) : 32'd0);
        if (e_w || e_r) begin
            chk("mem_addr", 32'(mem_addr), 32'(wrd));
            chk("mem_be", 32'(mem_be), 32'(be));
        end
        if (e_w) chk("mem_wdata", mem_wdata, wd);
        if (m_rret) chk("hrdata", HRDATA, mem_rdata);
        if (m_srv) chk("sec_rdata", sec_rdata, mem_rdata);
    endtask

    task automatic adv();
        bit acc, done;
        acc  = HSEL && HREADY && HTRANS[1];
        done = (m_op == 0) || (m_op == 1 && e_ag);
        m_rret = (m_op == 2 && e_ag);
        if (m_op == 2 && e_ag) m_op = 0;
        else if (done) begin
            if (acc) begin
                m_op = HWRITE ? 1 : 2; m_addr = HADDR[27:0]; m_size = HSIZE;
            end else m_op = 0;
        end
        m_wait = (!sec_req || e_sg) ? 0 : ((m_wait < 15) ? m_wait + 1 : 15);
        m_srv  = e_sg && !sec_write;
        @(posedge HCLK);
        #1;
    endtask

    task automatic ahb(input bit sel, input bit wr, input logic [31:0] addr, input logic [2:0] size);
        HSEL = sel; HTRANS = sel ? 2'b10 : 2'b00; HWRITE = wr; HADDR = addr; HSIZE = size;
    endtask

    initial begin
        HRESETn = 1'b0; HREADY = 1'b1;
        ahb(0, 0, '0, 3'd2); HWDATA = '0;
        sec_req = 0; sec_write = 0; sec_addr = '0; sec_wdata = '0; mem_rdata = '0;
        model_reset();
        #2;
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_sec_gnt", 32'(sec_gnt), 32'd0);
        chk("rst_sec_rvalid", 32'(sec_rvalid), 32'd0);
        chk("rst_wr_rd", 32'({mem_w_en, mem_r_en}), 32'd0);
        chk("rst_mem_cs", 32'(mem_cs), 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Word write 0x1200_0010
        ahb(1, 1, 32'h1200_0010, 3'd2); eval(); adv();
        ahb(0, 0, '0, 3'd2); HWDATA = 32'hDEAD_BEEF; eval();
        chk("wr_w_en", 32'(mem_w_en), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'h4);
        chk("wr_cs", 32'(mem_cs), 32'h0004);
        chk("wr_be", 32'(mem_be), 32'hF);
        chk("wr_ready", 32'(HREADYOUT), 32'd1);
        adv();

        // Byte read 0x0F00_0003
        ahb(1, 0, 32'h0F00_0003, 3'd0); eval(); adv();
        ahb(0, 0, '0, 3'd2); eval();
        chk("rd_ready", 32'(HREADYOUT), 32'd0);
        chk("rd_r_en", 32'(mem_r_en), 32'd1);
        chk("rd_be", 32'(mem_be), 32'b1000);
        chk("rd_cs", 32'(mem_cs), 32'h8000);
        adv();
        mem_rdata = 32'hA5A5_0F0F; eval();
        chk("rd_data_ready", 32'(HREADYOUT), 32'd1);
        chk("rd_hrdata", HRDATA, 32'hA5A5_0F0F);
        adv();

        // Back-to-back write then read
        ahb(1, 1, 32'h0300_0100, 3'd2); eval(); adv();
        ahb(1, 0, 32'h0300_0104, 3'd2); HWDATA = 32'h1234_5678; eval();
        chk("b2b_wr_ready", 32'(HREADYOUT), 32'd1); adv();
        ahb(0, 0, '0, 3'd2); eval();
        chk("b2b_rd_wait", 32'(HREADYOUT), 32'd0); adv();
        eval();
        chk("b2b_rd_done", 32'(HREADYOUT), 32'd1); adv();

        // Starvation with continuous writes
        ahb(1, 1, 32'h0500_0000, 3'd2); eval(); adv();
        sec_req = 1; sec_write = 1; sec_addr = {4'd6, 22'h11}; sec_wdata = 32'hCAFE_F00D;
        for (int i = 1; i <= 6; i++) begin
            HWDATA = $urandom;
            eval();
            chk("starve_gnt", 32'(sec_gnt), (i == 5) ? 32'd1 : 32'd0);
            if (i == 5) chk("starve_ready", 32'(HREADYOUT), 32'd0);
            if (i == 6) chk("starve_wait_clr", 32'(dut.wait_cnt), 32'd0);
            adv();
        end
        sec_req = 0; ahb(0, 0, '0, 3'd2);
        for (int i = 0; i < 3; i++) begin eval(); adv(); end

        // Secondary read bank 3 word 0x2A, AHB idle
        sec_req = 1; sec_write = 0; sec_addr = {4'd3, 22'h2A}; eval();
        chk("sec_rd_gnt", 32'(sec_gnt), 32'd1);
        chk("sec_rd_cs", 32'(mem_cs), 32'h0008);
        adv();
        sec_req = 0; eval();
        chk("sec_rd_valid", 32'(sec_rvalid), 32'd1);
        adv();

        // Reset during RD_ISSUE with a secondary read-valid pending
        ahb(1, 0, 32'h0200_0008, 3'd2); sec_req = 1; sec_write = 0; eval(); adv();
        ahb(0, 0, '0, 3'd2); sec_req = 0;
        #2; HRESETn = 1'b0; #1;
        chk("arst_ready", 32'(HREADYOUT), 32'd1);
        chk("arst_r_en", 32'(mem_r_en), 32'd0);
        chk("arst_cs", 32'(mem_cs), 32'd0);
        chk("arst_rvalid", 32'(sec_rvalid), 32'd0);
        model_reset();
        @(posedge HCLK); #1; HRESETn = 1'b1;
        eval();
        chk("arst_idle", 32'(dut.state), 32'(cmsdk_ahb_mem_pkg::IDLE));
        adv();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            HSEL = ($urandom_range(0, 3) != 0); HTRANS = 2'($urandom_range(0, 3));
            HWRITE = 1'($urandom); HSIZE = 3'($urandom_range(0, 2));
            HADDR = $urandom; HWDATA = $urandom;
            sec_req = ($urandom_range(0, 2) != 0); sec_write = 1'($urandom);
            sec_addr = 26'($urandom); sec_wdata = $urandom; mem_rdata = $urandom;
            eval();
            total++;
            assert (!(mem_w_en && mem_r_en)) else begin
                bad++;
                $error("FAIL both_en observed=%b%b expected=not both", mem_w_en, mem_r_en);
            end
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
